mem_responder: RTL and testbench

Memory-side responder for the core's single-master memory handshake. It accepts instruction fetches, loads and stores issued by the core control FSM on `en_mem`/`W_R_mem`, and services them from an on-chip word-organised RAM. It checks alignment, applies the programmable response latency, and returns `done_mem`, `busy_mem`, `aligned_mem` and sign/zero-extended read data. It sits between the core datapath and local instruction/data storage and is the counterpart of the core FSM's memory interface.

---
 rtl/mem_responder.sv | 173 +++++++++++++++++
 tb/tb_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the core's single-master memory handshake.
// Services loads, stores and fetches from a word-organised RAM with a fixed response latency.
module mem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_mem,
    input  logic [1:0]  W_R_mem,
    input  logic [1:0]  wordsize_mem,
    input  logic        sign_mem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy_mem,
    output logic        done_mem,
    output logic        aligned_mem
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp, StErr} state_e;

    state_e        state;
    logic [3:0]    cnt;
    logic [1:0]    op_q;
    logic [1:0]    size_q;
    logic          sign_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;

    logic [31:0]   ram [MEM_WORDS];

    logic [1:0]    op;
    logic [1:0]    size;
    logic          sgn;
    logic [AW+1:0] a;
    logic [31:0]   wd;
    logic [1:0]    eff_size;
    logic          is_store;
    logic          aligned_req;
    logic          go_resp;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   rext;

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    // On the accept edge the live inputs are the request; afterwards the latched copy is.
    always_comb begin
        if (state == StIdle) begin
            op   = W_R_mem;
            size = wordsize_mem;
            sgn  = sign_mem;
            a    = addr[AW+1:0];
            wd   = wdata;
        end else begin
            op   = op_q;
            size = size_q;
            sgn  = sign_q;
            a    = addr_q;
            wd   = wdata_q;
        end
    end

    always_comb begin
        is_store = (op == 2'b01);
        eff_size = ((op == 2'b11) || (size == 2'b11)) ? 2'b10 : size;
        case (eff_size)
            2'b00:   aligned_req = 1'b1;
            2'b01:   aligned_req = ~a[0];
            default: aligned_req = (a[1:0] == 2'b00);
        endcase
        go_resp = ((state == StIdle) && en_mem && aligned_req && (LATENCY == 0)) ||
                  ((state == StWait) && (cnt == 4'd0));
    end

    always_comb begin
        be    = 4'hF;
        wlane = wd;
        case (eff_size)
            2'b00: begin
                be    = 4'b0001 << a[1:0];
                wlane = {4{wd[7:0]}};
            end
            2'b01: begin
                be    = a[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wd[15:0]}};
            end
            default: begin
                be    = 4'hF;
                wlane = wd;
            end
        endcase
    end

    always_comb begin
        rword = ram[a[AW+1:2]];
        rbyte = rword[{a[1:0], 3'b000} +: 8];
        rhalf = rword[{a[1], 4'b0000} +: 16];
        case (eff_size)
            2'b00:   rext = {{24{sgn & rbyte[7]}}, rbyte};
            2'b01:   rext = {{16{sgn & rhalf[15]}}, rhalf};
            default: rext = rword;
        endcase
    end

    // Gated by reset so a store whose commit edge coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && go_resp && is_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[a[AW+1:2]][i*8 +: 8] <= wlane[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= StIdle;
            cnt         <= 4'd0;
            rdata       <= 32'd0;
            busy_mem    <= 1'b0;
            done_mem    <= 1'b0;
            aligned_mem <= 1'b1;
        end else begin
            done_mem <= 1'b0;
            case (state)
                StIdle: begin
                    if (en_mem) begin
                        op_q    <= W_R_mem;
                        size_q  <= wordsize_mem;
                        sign_q  <= sign_mem;
                        addr_q  <= addr[AW+1:0];
                        wdata_q <= wdata;
                        if (!aligned_req) begin
                            state       <= StErr;
                            aligned_mem <= 1'b0;
                        end else begin
                            busy_mem <= 1'b1;
                            if (LATENCY == 0) begin
                                state <= StResp;
                            end else begin
                                state <= StWait;
                                cnt   <= CNT_INIT;
                            end
                        end
                    end
                end
                StWait: begin
                    if (cnt == 4'd0) state <= StResp;
                    else             cnt   <= cnt - 4'd1;
                end
                StResp: begin
                    state    <= StIdle;
                    busy_mem <= 1'b0;
                end
                StErr: state <= StErr;
                default: state <= StIdle;
            endcase
            if (go_resp) begin
                done_mem <= 1'b1;
                if (!is_store) rdata <= rext;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (latency 2, 0, 3) against a
// byte-addressed reference memory model.
module tb_mem_responder;

    localparam int NI = 3;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_FETCH = 2'b11;
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;

    logic        clk = 1'b0;
    logic [NI-1:0] reset;
    logic [NI-1:0] en;
    logic [1:0]  w_r;
    logic [1:0]  wsize;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata   [NI];
    logic        busy    [NI];
    logic        done    [NI];
    logic        aligned [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_responder #(
            .MEM_WORDS(1024),
            .LATENCY  ((g == 0) ? 2 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk         (clk),
            .reset       (reset[g]),
            .en_mem      (en[g]),
            .W_R_mem     (w_r),
            .wordsize_mem(wsize),
            .sign_mem    (sign),
            .addr        (addr),
            .wdata       (wdata),
            .rdata       (rdata[g]),
            .busy_mem    (busy[g]),
            .done_mem    (done[g]),
            .aligned_mem (aligned[g])
        );
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  ref_mem [NI][4096];
    logic [31:0] rd_exp  [NI];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic int nbytes(input logic [1:0] op, input logic [1:0] sz);
        if (op == OP_FETCH) return 4;
        if (sz == SZ_BYTE) return 1;
        if (sz == SZ_HALF) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [1:0] op,
                                               input logic [1:0] sz, input logic sg,
                                               input logic [31:0] a);
        int nb;
        int base;
        logic [31:0] v;
        nb   = nbytes(op, sz);
        base = int'(a[11:0]);
        v    = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[d][(base + i) % 4096]) << (8 * i));
        if (op != OP_FETCH && sg && nb < 4 && v[8*nb-1])
            v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    task automatic model_store(input int d, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] wd);
        int nb;
        int base;
        nb   = nbytes(OP_STORE, sz);
        base = int'(a[11:0]);
        for (int i = 0; i < nb; i++) ref_mem[d][(base + i) % 4096] = wd[8*i +: 8];
    endtask

    task automatic rst(input int d);
        @(negedge clk);
        en[d]    = 1'b0;
        reset[d] = 1'b0;
        @(posedge clk);
        #1;
        reset[d]  = 1'b1;
        rd_exp[d] = 32'd0;
        check("reset busy", 32'(busy[d]), 32'd0);
        check("reset done", 32'(done[d]), 32'd0);
        check("reset aligned", 32'(aligned[d]), 32'd1);
        check("reset rdata", rdata[d], 32'd0);
    endtask

    // One full transaction with per-cycle busy/done checks; inputs are scrambled after
    // acceptance and, with poke set, en is raised again mid-request.
    task automatic req(input int d, input logic [1:0] op, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd,
                       input bit poke);
        int nb;
        int lt;
        bit mis;
        logic [31:0] exp_rd;
        nb  = nbytes(op, sz);
        lt  = lat(d);
        mis = (a % nb) != 0;
        exp_rd = model_load(d, op, sz, sg, a);
        @(negedge clk);
        w_r = op; wsize = sz; sign = sg; addr = a; wdata = wd;
        en[d] = 1'b1;
        @(posedge clk);
        #1;
        en[d] = 1'b0;
        w_r = 2'($urandom); wsize = 2'($urandom); sign = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        if (mis) begin
            check("misalign aligned", 32'(aligned[d]), 32'd0);
            check("misalign busy", 32'(busy[d]), 32'd0);
            check("misalign done", 32'(done[d]), 32'd0);
            return;
        end
        for (int k = 1; k <= lt + 1; k++) begin
            check("busy", 32'(busy[d]), 32'd1);
            check("done", 32'(done[d]), 32'(k == lt + 1));
            if (k == lt + 1) begin
                if (op != OP_STORE) rd_exp[d] = exp_rd;
                check("rdata", rdata[d], rd_exp[d]);
                if (op == OP_STORE) model_store(d, sz, a, wd);
            end else begin
                if (poke && k == 1) en[d] = 1'b1;
                @(posedge clk);
                #1;
                en[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("idle busy", 32'(busy[d]), 32'd0);
        check("idle done", 32'(done[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  op;
        logic [1:0]  sz;
        logic [31:0] a;
        int          nb;

        reset = '0; en = '0;
        w_r = 2'b00; wsize = 2'b00; sign = 1'b0; addr = 32'd0; wdata = 32'd0;
        for (int d = 0; d < NI; d++) rd_exp[d] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = '1;
        for (int d = 0; d < NI; d++) begin
            check("por busy", 32'(busy[d]), 32'd0);
            check("por done", 32'(done[d]), 32'd0);
            check("por aligned", 32'(aligned[d]), 32'd1);
            check("por rdata", rdata[d], 32'd0);
        end

        // Idle hold
        repeat (20) begin
            @(posedge clk);
            #1;
            check("idle hold busy", 32'(busy[0]), 32'd0);
            check("idle hold done", 32'(done[0]), 32'd0);
            check("idle hold aligned", 32'(aligned[0]), 32'd1);
            check("idle hold rdata", rdata[0], 32'd0);
        end

        // Word store then fetch
        req(0, OP_STORE, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        req(0, OP_FETCH, SZ_BYTE, 1'b1, 32'h10, 32'h0, 1'b0);
        check("fetch 0x10", rdata[0], 32'hDEADBEEF);

        // Byte/half lanes and extension
        req(0, OP_STORE, SZ_WORD, 1'b0, 32'h20, 32'h00000000, 1'b0);
        req(0, OP_STORE, SZ_BYTE, 1'b0, 32'h22, 32'hAAAAAA80, 1'b0);
        req(0, OP_STORE, SZ_HALF, 1'b0, 32'h20, 32'h5555F00D, 1'b0);
        req(0, OP_LOAD, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0);
        check("lanes word", rdata[0], 32'h0080F00D);
        req(0, OP_LOAD, SZ_BYTE, 1'b1, 32'h22, 32'h0, 1'b0);
        check("signed byte", rdata[0], 32'hFFFFFF80);
        req(0, OP_LOAD, SZ_BYTE, 1'b0, 32'h22, 32'h0, 1'b0);
        check("unsigned byte", rdata[0], 32'h00000080);
        req(0, OP_LOAD, SZ_HALF, 1'b1, 32'h20, 32'h0, 1'b0);
        check("signed half", rdata[0], 32'hFFFFF00D);

        // Misaligned word load sticks in error until reset
        req(0, OP_LOAD, SZ_WORD, 1'b0, 32'h13, 32'h0, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("err aligned", 32'(aligned[0]), 32'd0);
            check("err done", 32'(done[0]), 32'd0);
            check("err busy", 32'(busy[0]), 32'd0);
        end
        rst(0);
        req(0, OP_LOAD, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0);
        check("after err 0x10", rdata[0], 32'hDEADBEEF);

        // Address wrap, and en during WAIT ignored
        req(0, OP_STORE, SZ_WORD, 1'b0, 32'h1000, 32'h12345678, 1'b0);
        req(0, OP_LOAD, SZ_WORD, 1'b0, 32'h0000, 32'h0, 1'b1);
        check("wrap load", rdata[0], 32'h12345678);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("no extra done", 32'(done[0]), 32'd0);
        end

        // Zero latency
        req(1, OP_STORE, SZ_WORD, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0);
        req(1, OP_LOAD, SZ_HALF, 1'b0, 32'h42, 32'h0, 1'b1);
        check("lat0 half", rdata[1], 32'h0000CAFE);

        // Reset during WAIT drops the pending store
        req(2, OP_STORE, SZ_WORD, 1'b0, 32'h80, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        w_r = OP_STORE; wsize = SZ_WORD; sign = 1'b0; addr = 32'h80; wdata = 32'h11111111;
        en[2] = 1'b1;
        @(posedge clk);
        #1;
        en[2] = 1'b0;
        check("midop busy", 32'(busy[2]), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset[2] = 1'b0;
        @(posedge clk);
        #1;
        reset[2]  = 1'b1;
        rd_exp[2] = 32'd0;
        check("midop reset busy", 32'(busy[2]), 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("midop no done", 32'(done[2]), 32'd0);
        end
        req(2, OP_LOAD, SZ_WORD, 1'b0, 32'h80, 32'h0, 1'b0);
        check("midop word kept", rdata[2], 32'hA5A5A5A5);

        // Randomised traffic over a small initialised region, with aliased upper bits
        for (int i = 0; i < 16; i++)
            req(0, OP_STORE, SZ_WORD, 1'b0, 32'(i * 4), $urandom, 1'b0);
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom);
            sz = 2'($urandom);
            nb = nbytes(op, sz);
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            a  = a & ~32'(nb - 1);
            req(0, op, sz, 1'($urandom), a, $urandom, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
